// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: word size, default reset vector
// and the next-PC source encoding.
package mips_pkg;

   localparam int unsigned WORD_BYTES           = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_J,
      SEL_JR
   } pc_sel_e;

   // Fixed redirect priority: jr > jump > branch > sequential.
   function automatic pc_sel_e next_pc_sel(input logic jr, input logic jump,
                                           input logic branch_taken);
      pc_sel_e sel;
      sel = SEL_SEQ;
      if (jr)                sel = SEL_JR;
      else if (jump)         sel = SEL_J;
      else if (branch_taken) sel = SEL_BR;
      return sel;
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Redirect requests in, fetch address and status out. Return-address-stack
// signals exist only when PC_RAS_EN is defined.
interface pc_unit_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CNT_WIDTH = 32
);
   logic                 stall;
   logic                 branch_taken;
   logic [WIDTH-1:0]     branch_target;
   logic                 jump;
   logic [WIDTH-1:0]     jump_target;
   logic                 jr;
   logic [WIDTH-1:0]     jr_target;
   logic [WIDTH-1:0]     pc;
   logic [WIDTH-1:0]     pc_plus4;
   logic                 misalign_err;
   logic [CNT_WIDTH-1:0] instr_count;
`ifdef PC_RAS_EN
   logic                 link;
   logic                 ret;
   logic [WIDTH-1:0]     ras_top;
   logic                 ras_valid;
`endif

   modport master (
`ifdef PC_RAS_EN
      output link, ret,
      input  ras_top, ras_valid,
`endif
      output stall, branch_taken, branch_target, jump, jump_target, jr, jr_target,
      input  pc, pc_plus4, misalign_err, instr_count
   );

   modport slave (
`ifdef PC_RAS_EN
      input  link, ret,
      output ras_top, ras_valid,
`endif
      input  stall, branch_taken, branch_target, jump, jump_target, jr, jr_target,
      output pc, pc_plus4, misalign_err, instr_count
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// a pop when empty is ignored, and pop wins over a simultaneous push.
module pc_ras #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             valid
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    top_q, top_d;
   logic [PW:0]      cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      top_d = top_q;
      cnt_d = cnt_q;
      if (pop) begin
         if (cnt_q != '0) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - (PW+1)'(1);
         end
      end else if (push) begin
         // Index wraps naturally, so the slot after the newest is the oldest.
         top_d        = top_q + PW'(1);
         mem_d[top_d] = push_data;
         if (cnt_q != (PW+1)'(DEPTH)) cnt_d = cnt_q + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         top_q <= '1;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   assign top   = mem_q[top_q];
   assign valid = (cnt_q != '0);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, stall hold, sticky misalignment flag,
// saturating retire counter. Optional return-address stack via PC_RAS_EN.
module pc_unit
   import mips_pkg::*;
#(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
   parameter int unsigned      CNT_WIDTH    = 32,
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   pc_unit_if.slave  bus
);

   if (WIDTH < 8 || RESET_VECTOR[1:0] != 2'b00 || RAS_DEPTH < 2 || RAS_DEPTH > 16
       || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("pc_unit: illegal parameter combination");
   end

   pc_sel_e              sel;
   logic [WIDTH-1:0]     pc_q, pc_d;
   logic [WIDTH-1:0]     pc_plus4;
   logic [WIDTH-1:0]     target;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      pc_plus4 = pc_q + WIDTH'(WORD_BYTES);
      sel      = next_pc_sel(bus.jr, bus.jump, bus.branch_taken);
      case (sel)
         SEL_JR:  target = bus.jr_target;
         SEL_J:   target = bus.jump_target;
         SEL_BR:  target = bus.branch_target;
         default: target = pc_plus4;
      endcase

      pc_d  = pc_q;
      err_d = err_q;
      cnt_d = cnt_q;
      if (!bus.stall) begin
         // Low bits are forced clear; pc_plus4 is aligned so only redirects flag.
         pc_d = {target[WIDTH-1:2], 2'b00};
         if (target[1:0] != 2'b00) err_d = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VECTOR;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.pc_plus4     = pc_plus4;
   assign bus.misalign_err = err_q;
   assign bus.instr_count  = cnt_q;

`ifdef PC_RAS_EN
   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (bus.jump & bus.link & ~bus.stall),
      .pop       (bus.jr & bus.ret & ~bus.stall),
      .push_data (pc_plus4),
      .top       (bus.ras_top),
      .valid     (bus.ras_valid)
   );
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expected state, a monitor
// compares after every clock edge and on asynchronous reset assertion.
module tb_pc_unit;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pc_unit_if #(.WIDTH(32), .CNT_WIDTH(4)) bus ();

   pc_unit #(
      .WIDTH        (32),
      .RESET_VECTOR (32'h0040_0000),
      .CNT_WIDTH    (4),
      .RAS_DEPTH    (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [3:0]  cnt;
      logic        err;
      bit          chk_ras;
      bit          chk_top;
      logic [31:0] top;
      logic        valid;
   } exp_t;

   exp_t        sb[$];
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%h required=%h", n, act, req);
      end
   endtask

   task automatic push_exp(input string n, input logic [31:0] pc, input logic [3:0] cnt,
                           input logic err);
      exp_t e;
      e.name = n; e.pc = pc; e.cnt = cnt; e.err = err;
      e.chk_ras = 1'b0; e.chk_top = 1'b0; e.top = '0; e.valid = 1'b0;
      sb.push_back(e);
   endtask

   task automatic push_ras(input string n, input logic [31:0] pc, input logic [3:0] cnt,
                           input logic [31:0] top, input logic valid, input bit chk_top);
      exp_t e;
      e.name = n; e.pc = pc; e.cnt = cnt; e.err = 1'b0;
      e.chk_ras = 1'b1; e.chk_top = chk_top; e.top = top; e.valid = valid;
      sb.push_back(e);
   endtask

   task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic r, input logic [31:0] rt);
      bus.stall = s;
      bus.branch_taken = b; bus.branch_target = bt;
      bus.jump = j;         bus.jump_target = jt;
      bus.jr = r;           bus.jr_target = rt;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.name, " pc"},       bus.pc,                  e.pc);
            cmp({e.name, " pc_plus4"}, bus.pc_plus4,            e.pc + 32'd4);
            cmp({e.name, " count"},    {28'd0, bus.instr_count}, {28'd0, e.cnt});
            cmp({e.name, " misalign"}, {31'd0, bus.misalign_err}, {31'd0, e.err});
`ifdef PC_RAS_EN
            if (e.chk_ras) begin
               cmp({e.name, " ras_valid"}, {31'd0, bus.ras_valid}, {31'd0, e.valid});
               if (e.chk_top) cmp({e.name, " ras_top"}, bus.ras_top, e.top);
            end
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
`ifdef PC_RAS_EN
      bus.link = 1'b0;
      bus.ret  = 1'b0;
`endif
      #2;
      push_exp("reset", 32'h0040_0000, 4'd0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // 1: free-running sequential fetch
      push_exp("seq1", 32'h0040_0004, 4'd1, 1'b0); tick();
      push_exp("seq2", 32'h0040_0008, 4'd2, 1'b0); tick();
      push_exp("seq3", 32'h0040_000C, 4'd3, 1'b0); tick();

      // 2: priority jr > jump > branch
      drive(1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h100);
      push_exp("prio_jr", 32'h100, 4'd4, 1'b0); tick();
      drive(1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, '0);
      push_exp("prio_j", 32'h200, 4'd5, 1'b0); tick();
      drive(1'b0, 1'b0, '0, 1'b1, 32'h10, 1'b0, '0);
      push_exp("jump_10", 32'h10, 4'd6, 1'b0); tick();

      // 3: stall holds pc and count, branch taken after release
      drive(1'b1, 1'b1, 32'h80, 1'b0, '0, 1'b0, '0);
      push_exp("stall1", 32'h10, 4'd6, 1'b0); tick();
      push_exp("stall2", 32'h10, 4'd6, 1'b0); tick();
      drive(1'b0, 1'b1, 32'h80, 1'b0, '0, 1'b0, '0);
      push_exp("stall_rel", 32'h80, 4'd7, 1'b0); tick();

      // 4: misaligned target, sticky flag until reset
      drive(1'b0, 1'b0, '0, 1'b1, 32'h206, 1'b0, '0);
      push_exp("misalign", 32'h204, 4'd8, 1'b1); tick();
      drive(1'b0, 1'b0, '0, 1'b1, 32'h300, 1'b0, '0);
      push_exp("sticky_j", 32'h300, 4'd9, 1'b1); tick();
      drive(1'b0, 1'b1, 32'h400, 1'b0, '0, 1'b0, '0);
      push_exp("sticky_br", 32'h400, 4'd10, 1'b1); tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      push_exp("sticky_seq", 32'h404, 4'd11, 1'b1); tick();
      push_exp("rst_pulse", 32'h0040_0000, 4'd0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // 5: wrap-around, counter saturation, async reset mid-cycle
      drive(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
      push_exp("to_top", 32'hFFFF_FFFC, 4'd1, 1'b0); tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      push_exp("wrap", 32'h0, 4'd2, 1'b0); tick();
      for (int k = 1; k <= 18; k++) begin
         push_exp("sat_run", 32'(4 * k), 4'(((2 + k) > 15) ? 15 : (2 + k)), 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      push_exp("sat_stall", 32'h48, 4'd15, 1'b0); tick();
      @(posedge clk);
      #2;
      push_exp("async_rst", 32'h0040_0000, 4'd0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);

`ifdef PC_RAS_EN
      // 6: return-address stack overwrite and underflow
      begin
         logic [31:0] tops [5];
         logic [31:0] rets [4];
         tops = '{32'h04, 32'h14, 32'h24, 32'h34, 32'h44};
         rets = '{32'h34, 32'h24, 32'h14, 32'h0};
         drive(1'b0, 1'b0, '0, 1'b1, 32'h0, 1'b0, '0);
         push_ras("ras_start", 32'h0, 4'd1, '0, 1'b0, 1'b0); tick();
         bus.link = 1'b1;
         for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 32'((i + 1) * 16), 1'b0, '0);
            push_ras("ras_push", 32'((i + 1) * 16), 4'(2 + i), tops[i], 1'b1, 1'b1);
            tick();
         end
         drive(1'b1, 1'b0, '0, 1'b1, 32'h60, 1'b0, '0);
         push_ras("ras_stall", 32'h50, 4'd6, 32'h44, 1'b1, 1'b1); tick();
         bus.link = 1'b0;
         bus.ret  = 1'b1;
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h44);
         push_ras("ras_pop1", 32'h44, 4'd7, rets[0], 1'b1, 1'b1); tick();
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h34);
         push_ras("ras_pop2", 32'h34, 4'd8, rets[1], 1'b1, 1'b1); tick();
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h24);
         push_ras("ras_pop3", 32'h24, 4'd9, rets[2], 1'b1, 1'b1); tick();
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h14);
         push_ras("ras_pop4", 32'h14, 4'd10, rets[3], 1'b0, 1'b0); tick();
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h200);
         push_ras("ras_pop_empty", 32'h200, 4'd11, '0, 1'b0, 1'b0); tick();
         bus.link = 1'b1;
         drive(1'b0, 1'b0, '0, 1'b1, 32'h400, 1'b1, 32'h300);
         push_ras("ras_pop_wins", 32'h300, 4'd12, '0, 1'b0, 1'b0); tick();
         bus.link = 1'b0;
         bus.ret  = 1'b0;
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      end
`endif

      tick();
      tick();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
